// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue
//   Instruction-fetch front end. Owns the fetch PC and issues in-order
//   requests to a latency-tolerant instruction memory. Returned words are
//   buffered with their addresses in a DEPTH-entry prefetch FIFO and handed
//   to decode through a valid/ready handshake. A redirect flushes the FIFO,
//   restarts fetch at the new PC and squashes responses still in flight.
//
// Ports
//   clk             system clock, all state on the rising edge
//   rst             synchronous active-high reset
//   mem_req         fetch request valid (transfer = mem_req & mem_gnt)
//   mem_addr        fetch address, word aligned
//   mem_gnt         memory accepts the request this cycle
//   mem_rvalid      response word valid, responses return in request order
//   mem_rdata       response word
//   redirect_valid  flush and restart fetch at redirect_pc
//   redirect_pc     new fetch address, bits [1:0] ignored
//   ins_valid       FIFO head valid
//   ins             FIFO head instruction word
//   ins_addr        address of the FIFO head instruction
//   ins_ready       decode consumes the head (transfer = ins_valid & ins_ready)
//   occupancy       current FIFO entry count
// ---------------------------------------------------------------------------

// Simulation-only checks on the queue's internal invariants.
module ifetch_queue_chk #(
  parameter int CNT_W = 3,
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  input logic             push,
  input logic [CNT_W-1:0] count
);

  // The credit rule reserves a FIFO slot for every live request, so a push
  // can never land on a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    push |-> (count < CNT_W'(DEPTH)))
    else $error("ifetch_queue: push into full prefetch FIFO");

endmodule

module ifetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic                       mem_gnt,
  input  logic                       mem_rvalid,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       ins_valid,
  output logic [DATA_W-1:0]          ins,
  output logic [ADDR_W-1:0]          ins_addr,
  input  logic                       ins_ready,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int SUM_W = CNT_W + 1;

  logic [ADDR_W-1:0] fetch_pc_r;
  logic [ADDR_W-1:0] resp_pc_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  live_r;
  logic [CNT_W-1:0]  discard_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [ADDR_W-1:0] fifo_addr_r [DEPTH];
  logic [DATA_W-1:0] fifo_data_r [DEPTH];

  logic [SUM_W-1:0]  credit_sum_s;
  logic              issue_s;
  logic              push_s;
  logic              drop_s;
  logic              pop_s;
  logic [ADDR_W-1:0] redirect_base_s;
  logic [CNT_W-1:0]  redirect_discard_s;
  logic              unused_pc_bits_s;

  // Entries already buffered plus requests still owed a slot must fit.
  assign credit_sum_s = {1'b0, count_r} + {1'b0, live_r};
  assign mem_req      = !rst && !redirect_valid && (credit_sum_s < SUM_W'(DEPTH));
  assign mem_addr     = fetch_pc_r;
  assign issue_s      = mem_req && mem_gnt;

  // Squashed responses come back first (in-order memory), so they are
  // consumed by the discard counter before any live word is accepted.
  assign drop_s = mem_rvalid && !redirect_valid && (discard_r != '0);
  assign push_s = mem_rvalid && !redirect_valid && (discard_r == '0);

  assign ins_valid = (count_r != '0);
  assign ins       = fifo_data_r[rd_ptr_r];
  assign ins_addr  = fifo_addr_r[rd_ptr_r];
  assign occupancy = count_r;
  assign pop_s     = ins_valid && ins_ready;

  // Every live request becomes a discard on redirect; a word arriving in the
  // redirect cycle settles one of those outstanding requests on the spot.
  assign redirect_base_s    = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign redirect_discard_s = discard_r + live_r - CNT_W'(mem_rvalid);
  assign unused_pc_bits_s   = ^redirect_pc[1:0];

  // Fetch/response PCs, request accounting and FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r <= RESET_PC;
      resp_pc_r  <= RESET_PC;
      count_r    <= '0;
      live_r     <= '0;
      discard_r  <= '0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
    end else if (redirect_valid) begin
      fetch_pc_r <= redirect_base_s;
      resp_pc_r  <= redirect_base_s;
      count_r    <= '0;
      live_r     <= '0;
      discard_r  <= redirect_discard_s;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
    end else begin
      if (issue_s) begin
        fetch_pc_r <= fetch_pc_r + ADDR_W'(3'd4);
      end
      if (push_s) begin
        resp_pc_r <= resp_pc_r + ADDR_W'(3'd4);
        wr_ptr_r  <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (drop_s) begin
        discard_r <= discard_r - CNT_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      live_r  <= live_r + CNT_W'(issue_s) - CNT_W'(push_s);
      count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // FIFO payload storage; contents are only observed behind ins_valid, so
  // it carries no reset.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      fifo_addr_r[wr_ptr_r] <= resp_pc_r;
      fifo_data_r[wr_ptr_r] <= mem_rdata;
    end
  end

  ifetch_queue_chk #(
    .CNT_W (CNT_W),
    .DEPTH (DEPTH)
  ) u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .count (count_r)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

  localparam int          ADDR_W   = 32;
  localparam int          DATA_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          CNT_W    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              ins_valid;
  logic [DATA_W-1:0] ins;
  logic [ADDR_W-1:0] ins_addr;
  logic              ins_ready;
  logic [CNT_W-1:0]  occupancy;

  always #5 clk = ~clk;

  ifetch_queue #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ins_valid      (ins_valid),
    .ins            (ins),
    .ins_addr       (ins_addr),
    .ins_ready      (ins_ready),
    .occupancy      (occupancy)
  );

  // memory transaction: address the model expects, word the model expects,
  // word the memory actually returns, due cycle, fetch epoch at issue
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] mdata;
    int          due;
    int          epoch;
  } req_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  req_t pend[$];   // requests accepted by the memory, in order
  ent_t sb[$];     // expected FIFO contents, head first

  int total = 0;
  int bad   = 0;
  int n_pops = 0;
  int n_redirects = 0;
  int cyc = 0;
  int epoch = 0;
  int last_due = 0;
  logic [31:0] exp_fetch = RESET_PC;
  bit exp_req = 1'b0;
  logic [31:0] key = 32'h0;

  // stimulus knobs
  int gnt_pct = 100, rdy_pct = 100, redir_pct = 0, rst_pm = 0;
  int lat_min = 1, lat_max = 1;
  bit force_rst = 1'b0, force_redir = 1'b0;
  logic [31:0] force_pc = 32'h0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ key;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Driver + memory model + reference bookkeeping
  initial begin : driver
    bit p_rst, p_redir, p_rv;
    logic [31:0] p_rpc, p_rv_addr, p_rv_data;
    int p_rv_epoch, live, lat, due;
    ent_t e;
    req_t r;
    rst = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; ins_ready = 1'b0;
    p_rst = 1'b1; p_redir = 1'b0; p_rv = 1'b0; p_rpc = '0;
    p_rv_addr = '0; p_rv_data = '0; p_rv_epoch = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      // consequences of the cycle that just ended
      if (p_rst) begin
        pend.delete(); sb.delete(); epoch++; last_due = 0; exp_fetch = RESET_PC;
      end else if (p_redir) begin
        sb.delete(); epoch++; exp_fetch = p_rpc & 32'hFFFF_FFFC; n_redirects++;
      end else if (p_rv && p_rv_epoch == epoch) begin
        e.addr = p_rv_addr; e.data = p_rv_data; sb.push_back(e);
      end
      // inputs for this cycle
      rst = force_rst || ($urandom_range(0, 999) < rst_pm);
      redirect_valid = !rst && (force_redir || ($urandom_range(0, 99) < redir_pct));
      redirect_pc = force_redir ? force_pc : $urandom;
      force_rst = 1'b0; force_redir = 1'b0;
      mem_gnt = ($urandom_range(0, 99) < gnt_pct);
      ins_ready = ($urandom_range(0, 99) < rdy_pct);
      live = 0;
      foreach (pend[i]) if (pend[i].epoch == epoch) live++;
      exp_req = !rst && !redirect_valid && ((sb.size() + live) < DEPTH);
      if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
        r = pend.pop_front();
        mem_rvalid = 1'b1; mem_rdata = r.mdata;
        p_rv_addr = r.addr; p_rv_data = r.data; p_rv_epoch = r.epoch;
      end else begin
        mem_rvalid = 1'b0; mem_rdata = $urandom;
      end
      p_rst = rst; p_redir = redirect_valid; p_rpc = redirect_pc; p_rv = mem_rvalid;
      // request side, sampled mid-cycle
      @(negedge clk);
      chk("mem_req", mem_req, exp_req);
      if (!rst && mem_req && mem_gnt) begin
        chk("mem_addr", mem_addr, exp_fetch);
        lat = $urandom_range(lat_max, lat_min);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        r.addr = exp_fetch; r.data = word_of(exp_fetch); r.mdata = word_of(mem_addr);
        r.due = due; r.epoch = epoch;
        pend.push_back(r);
        exp_fetch = exp_fetch + 32'd4;
      end
    end
  end

  // Monitor: compares the decode-side outputs against the scoreboard
  initial begin : monitor
    ent_t e;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        chk("ins_valid", ins_valid, (sb.size() != 0));
        chk("occupancy", occupancy, sb.size());
        chk("occ_bound", (occupancy <= DEPTH), 1'b1);
        if (!rst && ins_valid && ins_ready && sb.size() > 0) begin
          e = sb.pop_front();
          chk("ins_addr", ins_addr, e.addr);
          chk("ins", ins, e.data);
          n_pops++;
        end
      end
    end
  end

  // Phase sequencing
  initial begin
    force_rst = 1'b1;
    // streaming, 1-cycle memory, word = address
    repeat (16) @(posedge clk);
    force_redir = 1'b1; force_pc = 32'h0000_5001;   // lands on rvalid and a handshake
    repeat (10) @(posedge clk);
    // decode stalled: FIFO fills to DEPTH and requests stop
    rdy_pct = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("full_occ", occupancy, DEPTH);
    chk("full_req", mem_req, 1'b0);
    rdy_pct = 100;
    repeat (12) @(posedge clk);
    // 3-cycle memory, redirect with requests in flight
    key = 32'h1234_5678; lat_min = 3; lat_max = 3;
    repeat (12) @(posedge clk);
    force_redir = 1'b1; force_pc = 32'h0000_4002;
    repeat (20) @(posedge clk);
    // reset mid-stream
    force_rst = 1'b1;
    repeat (15) @(posedge clk);
    // random traffic
    key = 32'hA5C3_0F96; gnt_pct = 50; rdy_pct = 60; redir_pct = 4; rst_pm = 3;
    lat_min = 1; lat_max = 5;
    repeat (4000) @(posedge clk);
    // drain
    redir_pct = 0; rst_pm = 0; gnt_pct = 100; rdy_pct = 100;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("progress", (n_pops > 500), 1'b1);
    chk("redirects_seen", (n_redirects > 10), 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
